// File: rtl/fm_demod_zc.sv
// Zero-crossing FM demodulator: measures the period between rising zero
// crossings and converts it to an NCO control word floor(2^32 / P).
// Optional build macro FM_DEMOD_AVG_EN: average over the last 4 accepted
// periods and compute floor(2^34 / sum) instead (35-cycle divide).
module fm_demod_zc #(
    parameter int unsigned CNT_W = 20,
    parameter int unsigned HYST  = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic signed [15:0] sample_in,
    output logic [31:0]        ctrl_out,
    output logic               ctrl_valid,
    output logic               busy,
    output logic               drop,
    output logic               ovf
);

`ifdef FM_DEMOD_AVG_EN
    localparam int unsigned DVS_W = CNT_W + 2;
    localparam int unsigned DIV_N = 35;
`else
    localparam int unsigned DVS_W = CNT_W;
    localparam int unsigned DIV_N = 33;
`endif
    localparam int unsigned REM_W = DVS_W + 1;
    localparam int unsigned IT_W  = 6;
    localparam int          NEG_HYST = -int'(HYST);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_IDLE, S_DIV} state_t;

    state_t             state_q, state_d;
    logic               arm_q, arm_d;
    logic               seen_q, seen_d;
    logic               inv_q, inv_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DVS_W-1:0]   dvs_q, dvs_d;
    logic [DVS_W-1:0]   rem_q, rem_d;
    logic [30:0]        quo_q, quo_d;
    logic [IT_W-1:0]    it_q, it_d;
    logic [31:0]        ctrl_out_q, ctrl_out_d;
    logic               ctrl_valid_q, ctrl_valid_d;
    logic               busy_q, busy_d;
    logic               drop_q, drop_d;
    logic               ovf_q, ovf_d;
`ifdef FM_DEMOD_AVG_EN
    logic [3:0][CNT_W-1:0] win_q, win_d;
    logic [2:0]            fill_q, fill_d;
    logic [DVS_W-1:0]      sum_q, sum_d;
`endif

    logic               crossing_c;
    logic [CNT_W-1:0]   per_c;
    logic               start_c;
    logic [DVS_W-1:0]   start_dvs_c;
    logic [REM_W-1:0]   shift_c;
    logic               qbit_c;

    assign crossing_c = sample_valid && arm_q && !sample_in[15];
    assign per_c      = cnt_q + CNT_W'(1);

    // Detector, period counter, crossing arbitration and divider sequencing
    always_comb begin
        state_d      = state_q;
        arm_d        = arm_q;
        seen_d       = seen_q;
        inv_d        = inv_q;
        cnt_d        = cnt_q;
        dvs_d        = dvs_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        it_d         = it_q;
        ctrl_out_d   = ctrl_out_q;
        ctrl_valid_d = 1'b0;
        drop_d       = 1'b0;
        ovf_d        = 1'b0;
        start_c      = 1'b0;
        start_dvs_c  = '0;
        shift_c      = '0;
        qbit_c       = 1'b0;
`ifdef FM_DEMOD_AVG_EN
        win_d        = win_q;
        fill_d       = fill_q;
        sum_d        = sum_q;
`endif

        if (sample_valid) begin
            if (crossing_c) begin
                arm_d  = 1'b0;
                cnt_d  = '0;
                inv_d  = 1'b0;
                seen_d = 1'b1;
                if (seen_q) begin
                    if (inv_q) begin
                        ovf_d = 1'b1;
`ifdef FM_DEMOD_AVG_EN
                        fill_d = '0;
                        sum_d  = '0;
`endif
                    end else if (state_q == S_DIV) begin
                        drop_d = 1'b1;
`ifdef FM_DEMOD_AVG_EN
                        fill_d = '0;
                        sum_d  = '0;
`endif
                    end else begin
`ifdef FM_DEMOD_AVG_EN
                        win_d  = {win_q[2:0], per_c};
                        sum_d  = sum_q + DVS_W'(per_c)
                               - ((fill_q == 3'd4) ? DVS_W'(win_q[3]) : '0);
                        fill_d = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
                        if (fill_d == 3'd4) begin
                            start_c     = 1'b1;
                            start_dvs_c = sum_d;
                        end
`else
                        start_c     = 1'b1;
                        start_dvs_c = per_c;
`endif
                    end
                end
            end else begin
                if (int'(sample_in) <= NEG_HYST) begin
                    arm_d = 1'b1;
                end
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_MAX - CNT_W'(1)) begin
                        inv_d = 1'b1;
                    end
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    state_d = S_DIV;
                    dvs_d   = start_dvs_c;
                    rem_d   = '0;
                    quo_d   = '0;
                    it_d    = '0;
                end
            end
            S_DIV: begin
                // Dividend is a single leading one followed by zeros
                shift_c = {rem_q, (it_q == '0)};
                if (shift_c >= {1'b0, dvs_q}) begin
                    qbit_c = 1'b1;
                    rem_d  = DVS_W'(shift_c - {1'b0, dvs_q});
                end else begin
                    rem_d  = shift_c[DVS_W-1:0];
                end
                quo_d = {quo_q[29:0], qbit_c};
                it_d  = it_q + IT_W'(1);
                if (it_q == IT_W'(DIV_N - 1)) begin
                    state_d      = S_IDLE;
                    ctrl_out_d   = {quo_q, qbit_c};
                    ctrl_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_DIV);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            arm_q        <= 1'b0;
            seen_q       <= 1'b0;
            inv_q        <= 1'b0;
            cnt_q        <= '0;
            dvs_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            it_q         <= '0;
            ctrl_out_q   <= '0;
            ctrl_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef FM_DEMOD_AVG_EN
            win_q        <= '0;
            fill_q       <= '0;
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            arm_q        <= arm_d;
            seen_q       <= seen_d;
            inv_q        <= inv_d;
            cnt_q        <= cnt_d;
            dvs_q        <= dvs_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            it_q         <= it_d;
            ctrl_out_q   <= ctrl_out_d;
            ctrl_valid_q <= ctrl_valid_d;
            busy_q       <= busy_d;
            drop_q       <= drop_d;
            ovf_q        <= ovf_d;
`ifdef FM_DEMOD_AVG_EN
            win_q        <= win_d;
            fill_q       <= fill_d;
            sum_q        <= sum_d;
`endif
        end
    end

    assign ctrl_out   = ctrl_out_q;
    assign ctrl_valid = ctrl_valid_q;
    assign busy       = busy_q;
    assign drop       = drop_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_fm_demod_zc.sv
// Bench for fm_demod_zc: two instances (CNT_W=20 and CNT_W=8) on shared
// stimulus, each compared every cycle against a period/latency model.
module tb_fm_demod_zc;
    localparam int unsigned HYST = 256;
    localparam int CW_A = 20;
    localparam int CW_B = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              sample_valid;
    logic signed [15:0] sample_in;
    logic [1:0][31:0]  co;
    logic [1:0]        cv, bz, dp, ov;

    fm_demod_zc #(.CNT_W(CW_A), .HYST(HYST)) dut_a (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
        .ctrl_out(co[0]), .ctrl_valid(cv[0]), .busy(bz[0]), .drop(dp[0]), .ovf(ov[0]));

    fm_demod_zc #(.CNT_W(CW_B), .HYST(HYST)) dut_b (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
        .ctrl_out(co[1]), .ctrl_valid(cv[1]), .busy(bz[1]), .drop(dp[1]), .ovf(ov[1]));

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Reference model state: samples since last crossing, pending result
    bit          m_arm[2], m_seen[2], m_pend[2];
    int          m_cnt[2], m_acc[2];
    logic [31:0] m_res[2], m_ctrl[2];
    bit          e_cv[2], e_dp[2], e_ov[2], e_bz[2];
    int          n_cv[2], n_dp[2], n_ov[2];

    typedef struct {
        int          period;
        bit          gaps;
        int          nper;
        logic [31:0] exp_ctrl;
        bit          exp_drop;
    } vec_t;
    vec_t vecs[4];

    function automatic int cnt_max(input int k);
        return (k == 0) ? ((1 << CW_A) - 1) : ((1 << CW_B) - 1);
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d edge %0d: got %h expected %h", name, k, edge_n, act, exp);
        end
    endtask

    function automatic void model_step(input int k, input bit r, input bit v, input int s);
        bit busy_now;
        int p;
        logic [63:0] q;
        e_cv[k] = 1'b0;
        e_dp[k] = 1'b0;
        e_ov[k] = 1'b0;
        if (r) begin
            m_arm[k] = 1'b0; m_seen[k] = 1'b0; m_cnt[k] = 0; m_pend[k] = 1'b0;
            m_ctrl[k] = '0; e_bz[k] = 1'b0;
            return;
        end
        busy_now = m_pend[k] && (edge_n <= m_acc[k] + 33);
        if (m_pend[k] && edge_n == m_acc[k] + 33) begin
            m_ctrl[k] = m_res[k];
            e_cv[k]   = 1'b1;
            m_pend[k] = 1'b0;
        end
        if (v) begin
            if (m_arm[k] && s >= 0) begin
                p = m_cnt[k] + 1;
                m_cnt[k] = 0;
                m_arm[k] = 1'b0;
                if (m_seen[k]) begin
                    if (p > cnt_max(k)) e_ov[k] = 1'b1;
                    else if (busy_now) e_dp[k] = 1'b1;
                    else begin
                        m_pend[k] = 1'b1;
                        m_acc[k]  = edge_n;
                        q = 64'h1_0000_0000 / 64'(p);
                        m_res[k] = q[31:0];
                    end
                end
                m_seen[k] = 1'b1;
            end else begin
                if (s <= -int'(HYST)) m_arm[k] = 1'b1;
                m_cnt[k]++;
            end
        end
        e_bz[k] = m_pend[k];
    endfunction

    task automatic tick(input bit v, input int s);
        sample_valid = v;
        sample_in    = 16'(s);
        @(posedge clk);
        edge_n++;
        for (int k = 0; k < 2; k++) model_step(k, rst, v, s);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("ctrl_out",   k, co[k],      m_ctrl[k]);
            check("ctrl_valid", k, 32'(cv[k]), 32'(e_cv[k]));
            check("busy",       k, 32'(bz[k]), 32'(e_bz[k]));
            check("drop",       k, 32'(dp[k]), 32'(e_dp[k]));
            check("ovf",        k, 32'(ov[k]), 32'(e_ov[k]));
            n_cv[k] += int'(cv[k]);
            n_dp[k] += int'(dp[k]);
            n_ov[k] += int'(ov[k]);
        end
    endtask

    task automatic clear_tallies();
        for (int k = 0; k < 2; k++) begin
            n_cv[k] = 0; n_dp[k] = 0; n_ov[k] = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, int'($urandom_range(0, 65535)) - 32768);
    endtask

    task automatic wave(input int p, input bit gaps, input int nper);
        for (int i = 0; i < nper; i++) begin
            for (int j = 0; j < p; j++) begin
                tick(1'b1, (j < p / 2) ? 1000 : -1000);
                if (gaps) tick(1'b0, -int'($urandom_range(0, 32768)));
            end
        end
    endtask

    initial begin
        logic [31:0] ph;
        vecs[0] = '{64,  1'b0, 6, 32'h0400_0000, 1'b0};
        vecs[1] = '{100, 1'b0, 4, 32'h028F_5C28, 1'b0};
        vecs[2] = '{100, 1'b1, 4, 32'h028F_5C28, 1'b0};
        vecs[3] = '{20,  1'b0, 8, 32'h0CCC_CCCC, 1'b1};

        rst = 1'b1;
        sample_valid = 1'b0;
        sample_in = '0;
        for (int i = 0; i < 3; i++) tick(1'b0, 0);
        for (int k = 0; k < 2; k++) check("reset_ctrl_out", k, co[k], 32'h0);
        rst = 1'b0;

        // NCO sine at ctrl 0x0400_0000: crossings every 64 samples
        clear_tallies();
        ph = '0;
        for (int i = 0; i < 6 * 64; i++) begin
            tick(1'b1, $rtoi(20000.0 * $sin(2.0 * 3.14159265358979 * real'(ph) / 4294967296.0)));
            ph = ph + 32'h0400_0000;
        end
        idle(40);
        for (int k = 0; k < 2; k++) begin
            check("sine_ctrl", k, co[k], 32'h0400_0000);
            check("sine_results", k, 32'(n_cv[k]), 32'd4);
        end

        // Table of synthetic square-ish waves
        for (int v = 0; v < 4; v++) begin
            clear_tallies();
            wave(vecs[v].period, vecs[v].gaps, vecs[v].nper);
            idle(40);
            for (int k = 0; k < 2; k++) begin
                check("vec_ctrl", k, co[k], vecs[v].exp_ctrl);
                check("vec_drop_seen", k, 32'(n_dp[k] > 0), 32'(vecs[v].exp_drop));
            end
        end

        // Small noise never re-arms the detector
        tick(1'b1, 1000);
        idle(40);
        clear_tallies();
        for (int i = 0; i < 500; i++) tick(1'b1, int'($urandom_range(0, 200)) - 100);
        for (int k = 0; k < 2; k++)
            check("noise_events", k, 32'(n_cv[k] + n_dp[k] + n_ov[k]), 32'd0);

        // Long negative hold overflows the 8-bit counter only
        wave(64, 1'b0, 2);
        idle(40);
        clear_tallies();
        for (int i = 0; i < 300; i++) tick(1'b1, -1000);
        wave(64, 1'b0, 3);
        idle(40);
        check("ovf_count",     1, 32'(n_ov[1]), 32'd1);
        check("ovf_results",   1, 32'(n_cv[1]), 32'd2);
        check("ovf_ctrl",      1, co[1], 32'h0400_0000);
        check("no_ovf_wide",   0, 32'(n_ov[0]), 32'd0);

        // Reset in the middle of a divide
        tick(1'b1, 1000);
        for (int i = 0; i < 10; i++) tick(1'b1, -1000);
        for (int k = 0; k < 2; k++) check("div_busy", k, 32'(bz[k]), 32'd1);
        rst = 1'b1;
        tick(1'b1, -1000);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("rst_busy", k, 32'(bz[k]), 32'd0);
            check("rst_ctrl", k, co[k], 32'h0);
        end
        clear_tallies();
        for (int i = 0; i < 40; i++) tick(1'b1, -1000);
        wave(64, 1'b0, 1);
        idle(40);
        for (int k = 0; k < 2; k++) check("rst_first_xing", k, 32'(n_cv[k]), 32'd0);

        // Randomized segments
        for (int seg = 0; seg < 40; seg++) begin
            int p, npos;
            bit gaps;
            p = int'($urandom_range(2, 300));
            npos = int'($urandom_range(1, p - 1));
            gaps = ($urandom_range(0, 3) == 0);
            for (int j = 0; j < p; j++) begin
                int s;
                if (j < npos) s = int'($urandom_range(0, 32767));
                else s = -int'($urandom_range(1, 32768));
                if (gaps && $urandom_range(0, 1) == 1) tick(1'b0, -s);
                tick(1'b1, s);
            end
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 40)));
        end
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
